// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out frame serializer: accepts an N-bit word over valid/ready
// and shifts out 1..N bits per word, MSB- or LSB-first, gated by an external bit strobe.
module piso_frame_serializer #(
    parameter int N     = 8,
    parameter int LEN_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_data,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_direction,
    input  logic             i_shift_en,
    output logic             o_out,
    output logic             o_out_valid,
    output logic             o_last
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic MSB_FIRST = 1'b0;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [0:0]       state_reg, state_next;
    logic [N-1:0]     q_reg, q_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic             dir_reg, dir_next;

    logic             in_shift;
    logic             accept;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] align_sh;
    logic [N-1:0]     load_q;
    logic [N-1:0]     q_shl;
    logic [N-1:0]     q_shr;

    // One-bit shifted views of q, zero filled at the vacated end.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_shift
            if (gi == 0) begin : g_lo
                assign q_shl[gi] = 1'b0;
                assign q_shr[gi] = q_reg[gi+1];
            end else if (gi == N - 1) begin : g_hi
                assign q_shl[gi] = q_reg[gi-1];
                assign q_shr[gi] = 1'b0;
            end else begin : g_mid
                assign q_shl[gi] = q_reg[gi-1];
                assign q_shr[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    assign in_shift    = (state_reg == ST_SHIFT);
    assign o_out_valid = in_shift;
    assign o_last      = in_shift && (cnt_reg == LEN_ONE);
    assign o_out       = in_shift && ((dir_reg == MSB_FIRST) ? q_reg[N-1] : q_reg[0]);

    // In SHIFT a new word can only land on the cycle the last bit is consumed.
    assign o_ready = rst && (!in_shift || (o_last && i_shift_en));
    assign accept  = i_valid && o_ready;

    assign len_eff  = ((i_len == '0) || (i_len > LEN_MAX)) ? LEN_MAX : i_len;
    assign align_sh = LEN_MAX - len_eff;
    // MSB-first words are left-aligned so the first bit always sits at q[N-1].
    assign load_q   = (i_direction == MSB_FIRST) ? (i_data << align_sh) : i_data;

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        if (accept) begin
            state_next = ST_SHIFT;
            q_next     = load_q;
            cnt_next   = len_eff;
            dir_next   = i_direction;
        end else if (in_shift && i_shift_en) begin
            if (cnt_reg > LEN_ONE) begin
                q_next   = (dir_reg == MSB_FIRST) ? q_shl : q_shr;
                cnt_next = cnt_reg - LEN_ONE;
            end else begin
                state_next = ST_IDLE;
                q_next     = '0;
                cnt_next   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            q_reg     <= '0;
            cnt_reg   <= '0;
            dir_reg   <= MSB_FIRST;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
        end
    end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Bench for piso_frame_serializer: directed scenarios plus random traffic, checked
// every cycle against a queue-of-pending-bits reference model.
module tb_piso_frame_serializer;

    localparam int N     = 8;
    localparam int LEN_W = $clog2(N + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid;
    logic             o_ready;
    logic [N-1:0]     i_data;
    logic [LEN_W-1:0] i_len;
    logic             i_direction;
    logic             i_shift_en;
    logic             o_out;
    logic             o_out_valid;
    logic             o_last;

    piso_frame_serializer #(.N(N), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_len       (i_len),
        .i_direction (i_direction),
        .i_shift_en  (i_shift_en),
        .o_out       (o_out),
        .o_out_valid (o_out_valid),
        .o_last      (o_last)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: bits still to be shown for the current word, front = on o_out.
    bit cur_bits[$];
    // Words waiting to be offered.
    logic [N-1:0]     pend_data[$];
    logic [LEN_W-1:0] pend_len[$];
    logic             pend_dir[$];

    int en_mode    = 0;  // 0: strobe always 1, 1: pattern 1,0,0, 2: random
    int rand_valid = 0;  // insert random gaps in i_valid
    int pat_idx    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic push_word(input logic [N-1:0] d, input logic [LEN_W-1:0] l, input logic dir);
        pend_data.push_back(d);
        pend_len.push_back(l);
        pend_dir.push_back(dir);
    endtask

    // Expand a word into its transmitted bit order.
    task automatic load_bits(input logic [N-1:0] d, input logic [LEN_W-1:0] l, input logic dir);
        int len;
        len = (l == 0 || int'(l) > N) ? N : int'(l);
        cur_bits.delete();
        for (int i = 0; i < len; i++)
            cur_bits.push_back(dir ? d[i] : d[len-1-i]);
    endtask

    task automatic check_outputs(input string ph);
        logic exp_valid, exp_out, exp_last, exp_ready;
        exp_valid = (cur_bits.size() > 0);
        exp_out   = exp_valid ? cur_bits[0] : 1'b0;
        exp_last  = (cur_bits.size() == 1);
        exp_ready = rst && (cur_bits.size() == 0 || (cur_bits.size() == 1 && i_shift_en));
        chk({ph, "_out_valid"}, 32'(o_out_valid), 32'(exp_valid));
        chk({ph, "_out"},       32'(o_out),       32'(exp_out));
        chk({ph, "_last"},      32'(o_last),      32'(exp_last));
        chk({ph, "_ready"},     32'(o_ready),     32'(exp_ready));
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic tick();
        logic v, en, exp_acc;
        v = (pend_data.size() > 0) && (rand_valid == 0 || $urandom_range(0, 3) != 0);
        case (en_mode)
            0:       en = 1'b1;
            1:       en = (pat_idx % 3 == 0);
            default: en = ($urandom_range(0, 9) < 7);
        endcase
        pat_idx++;
        i_valid     = v;
        i_data      = v ? pend_data[0] : N'($urandom);
        i_len       = v ? pend_len[0]  : LEN_W'($urandom);
        i_direction = v ? pend_dir[0]  : 1'($urandom);
        i_shift_en  = en;
        @(negedge clk);
        check_outputs("cyc");
        exp_acc = rst && v && (cur_bits.size() == 0 || (cur_bits.size() == 1 && en));
        @(posedge clk);
        if (rst) begin
            if (en && cur_bits.size() > 0) void'(cur_bits.pop_front());
            if (exp_acc) begin
                load_bits(pend_data[0], pend_len[0], pend_dir[0]);
                void'(pend_data.pop_front());
                void'(pend_len.pop_front());
                void'(pend_dir.pop_front());
            end
        end
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((pend_data.size() > 0 || cur_bits.size() > 0) && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n >= max_cycles), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        rst         = 1'b0;
        i_valid     = 1'b0;
        i_data      = '0;
        i_len       = '0;
        i_direction = 1'b0;
        i_shift_en  = 1'b1;

        // Reset held with a word offered: no accept, ready low.
        push_word(8'hA5, 4'd8, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        drain(100);

        // LSB-first short word, then a 3-bit MSB-first word.
        push_word(8'hA5, 4'd4, 1'b1);
        push_word(8'hF0, 4'd3, 1'b0);
        drain(100);

        // Back-to-back with i_valid held.
        push_word(8'h81, 4'd8, 1'b0);
        push_word(8'h7E, 4'd8, 1'b0);
        drain(100);

        // Stalling strobe.
        en_mode = 1;
        pat_idx = 0;
        push_word(8'hC3, 4'd8, 1'b0);
        drain(200);
        en_mode = 0;

        // Length edge cases.
        push_word(8'h5A, 4'd0, 1'b0);
        push_word(8'h3C, 4'd9, 1'b1);
        push_word(8'h01, 4'd1, 1'b1);
        push_word(8'hFE, 4'd1, 1'b0);
        drain(100);

        // Asynchronous reset in the middle of a frame.
        push_word(8'hFF, 4'd8, 1'b0);
        repeat (4) tick();
        #2;
        rst = 1'b0;
        #1;
        cur_bits.delete();
        pend_data.delete();
        pend_len.delete();
        pend_dir.delete();
        chk("async_rst_valid", 32'(o_out_valid), 32'd0);
        chk("async_rst_out",   32'(o_out),       32'd0);
        chk("async_rst_ready", 32'(o_ready),     32'd0);
        @(posedge clk);
        #1;
        repeat (2) tick();
        rst = 1'b1;
        repeat (4) tick();

        // Random traffic.
        en_mode    = 2;
        rand_valid = 1;
        for (int w = 0; w < 300; w++)
            push_word(N'($urandom), LEN_W'($urandom_range(0, 15)), 1'($urandom));
        drain(20000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/piso_frame_serializer.md
Name: piso_frame_serializer

Overview:
- Parametrised successor to the team's fixed-width parallel-to-serial shift register.
- Accepts an N-bit word through a valid/ready handshake and serialises it one bit per enabled cycle, MSB-first or LSB-first.
- Frame length is per-word programmable (1..N bits).
- Supports back-to-back words with no idle bit, so it can drive SPI/UART-style TX paths whose bit rate comes from an external strobe.

Parameters:
- N, 8, maximum word width in bits (N >= 2).
- LEN_W, $clog2(N+1), width of the length field.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low: asserted at 0, released at 1.
- i_valid  in  1  word offered on i_data/i_len/i_direction.
- o_ready  out  1  serializer can accept a word this cycle.
- i_data  in  N  parallel word; only bits [len-1:0] are transmitted.
- i_len  in  LEN_W  bits to send; 0 or >N means N.
- i_direction  in  1  shift_direction_t_ (MSB_FIRST=0, LSB_FIRST=1); sampled only at accept.
- i_shift_en  in  1  bit strobe; the current bit is consumed on a posedge where this is 1.
- o_out  out  1  serial data bit.
- o_out_valid  out  1  o_out carries a frame bit.
- o_last  out  1  o_out is the final bit of the current word.

Behaviour:
- Accept means a posedge with i_valid=1 and o_ready=1.
- State: IDLE or SHIFT. Registers: q[N-1:0], cnt[LEN_W-1:0], dir.
- Reset (rst=0, async):
  - state=IDLE, q=0, cnt=0, dir=MSB_FIRST.
  - o_out=0, o_out_valid=0, o_last=0.
  - o_ready is forced 0 while rst=0.
  - Reset mid-frame aborts the frame immediately; remaining bits are never emitted.
- IDLE:
  - o_ready=1, o_out_valid=0, o_out=0, o_last=0.
  - On accept: go to SHIFT. cnt=len_eff, dir=i_direction.
  - q load for MSB_FIRST: q = i_data << (N-len_eff), left-aligned so bit len_eff-1 lands at q[N-1].
  - q load for LSB_FIRST: q = i_data.
  - Latency: the first bit appears on o_out the cycle after accept.
- SHIFT:
  - o_out_valid=1.
  - o_out = q[N-1] when dir=MSB_FIRST, q[0] when dir=LSB_FIRST.
  - o_last = (cnt==1).
- Posedge with i_shift_en=1 and cnt>1:
  - MSB_FIRST shifts left with zero fill; LSB_FIRST shifts right with zero fill.
  - cnt decrements.
- Posedge with i_shift_en=0: q, cnt and o_out all hold; the bit stays on o_out indefinitely.
- o_ready in SHIFT = o_last & i_shift_en, combinational, for back-to-back operation.
  - Accept on the last-bit cycle: reload q/cnt/dir exactly as from IDLE and stay in SHIFT. The new word's first bit follows the old last bit with no gap cycle.
  - Last bit consumed with no accept: go to IDLE; o_out_valid drops the next cycle.
- i_data, i_len and i_direction are don't-care except on an accept. Changing i_direction mid-frame has no effect.
- Bits of i_data at positions >= len_eff are never transmitted.
- len_eff=1: the word occupies exactly one enabled cycle with o_last=1 throughout.
- i_valid held with o_ready=0 is simply pending. The serializer never drops or duplicates a word.

Test Plan:
- Reset and MSB frame: N=8, reset low for 3 cycles then release; i_shift_en=1. Accept i_data=8'hA5, len=8, MSB_FIRST → o_ready=0 during reset. From the next cycle, o_out=1,0,1,0,0,1,0,1 with o_out_valid=1, o_last only on the 8th bit, then IDLE with o_ready=1.
- LSB and short length: accept 8'hA5, len=4, LSB_FIRST → o_out=1,0,1,0 (4 bits), o_last on the 4th. Then accept 8'hF0, len=3, MSB_FIRST → o_out=0,0,0.
- Back-to-back: i_valid held high with words 8'h81 then 8'h7E, len=8, MSB_FIRST → 16 consecutive valid bits 1,0,0,0,0,0,0,1,0,1,1,1,1,1,1,0 with no gap. o_ready pulses only on the two o_last cycles (plus the initial IDLE cycle).
- Stall: i_shift_en toggling 1,0,0,1,... during 8'hC3 MSB_FIRST → each bit held while i_shift_en=0. Sequence 1,1,0,0,0,0,1,1 is preserved. o_ready=0 when o_last=1 and i_shift_en=0.
- Length edge cases: len=0 and len=9 → full 8 bits sent. len=1 with 8'h01 LSB_FIRST → single bit 1 with o_last=1.
- Async reset mid-frame: drop rst after 3 bits of 8'hFF at a non-clock-edge time → o_out_valid and o_out go 0 immediately. After release, o_ready=1 and no residual bits are emitted.
